// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// fixed latency of XLEN+3 cycles from acceptance to the done pulse.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] Result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     op1_q, op1_d;
  logic [XLEN-1:0]     op2_q, op2_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                signed1, signed2, s1, s2;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     fix_val;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_PREP;
      S_PREP: state_d = S_CALC;
      S_CALC: if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_DONE) && !flush_i;
    Result_o = result_q;
  end

  // Operand sign decode and per-step arithmetic
  always_comb begin
    signed1 = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    signed2 = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    s1      = signed1 && op1_q[XLEN-1];
    s2      = signed2 && op2_q[XLEN-1];

    // Multiplier is consumed LSB-first from b_q; carry lives only inside mul_sum.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Dividend bits stream in MSB-first from a_q; {rem, quot} share the accumulator.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, b_q};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and result select
  always_comb begin
    prod     = neg_q ? ('0 - acc_q) : acc_q;
    quot     = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem      = neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    div_zero = (op2_q == '0);
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (op1_q == MIN_INT) && (op2_q == '1);
    fix_val  = '0;
    unique case (op_q)
      OP_MUL:                       fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero)     fix_val = '1;
        else if (div_ovf) fix_val = MIN_INT;
        else              fix_val = quot;
      end
      OP_REM, OP_REMU: begin
        if (div_zero)     fix_val = op1_q;
        else if (div_ovf) fix_val = '0;
        else              fix_val = rem;
      end
      default: fix_val = '0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d  = op_i;
          op1_d = src1;
          op2_d = src2;
        end
      end
      S_PREP: begin
        a_d   = s1 ? ('0 - op1_q) : op1_q;
        b_d   = s2 ? ('0 - op2_q) : op2_q;
        neg_d = (op_q[2] && op_q[1]) ? s1 : (s1 ^ s2);
        acc_d = '0;
        cnt_d = '0;
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = div_next;
          a_d   = a_q << 1;
        end else begin
          acc_d = mul_next;
          b_d   = b_q >> 1;
        end
      end
      S_FIX: begin
        if (!flush_i) result_d = fix_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake, flush and reset sequences.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] Result_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .src1     (src1),
    .src2     (src2),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .Result_o (Result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Accepts a request; returns in the first cycle after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; src1 = a; src2 = b; start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  // Waits for done from cycle index 'first'; returns lat=-1 on timeout.
  task automatic wait_done(input int first, output logic [31:0] res, output int lat,
                           output int busy_cnt);
    res = '0; lat = -1; busy_cnt = 0;
    for (int i = first; i <= 60; i++) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = i;
        res = Result_o;
        break;
      end
      step(1);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt);
    start_op(op, a, b);
    wait_done(1, res, lat, busy_cnt);
    step(1);
  endtask

  task automatic no_done(input string name, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      if (done_o || busy_o) cnt++;
      step(1);
    end
    chk(name, 32'(cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int lat, bc, dcnt, didx;
    string nm;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[13] = '{3'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
    vecs[14] = '{3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA};
    vecs[15] = '{3'd6, 32'd20,        32'hFFFF_FFFD, 32'd2};
    vecs[16] = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vecs[17] = '{3'd7, 32'd5,         32'd0,         32'd5};
    vecs[18] = '{3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF};
    vecs[19] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};

    // Reset state
    step(2);
    rst_i = 1'b0;
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_result", Result_o, 32'd0);

    // Back-to-back vectors also prove a start one cycle after done is accepted
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
      nm = $sformatf("vec%0d_result", i);
      chk(nm, res, vecs[i].exp);
      nm = $sformatf("vec%0d_latency", i);
      chk(nm, 32'(lat), 32'd35);
      nm = $sformatf("vec%0d_busy", i);
      chk(nm, 32'(bc), 32'd35);
    end

    // start_i held high: one done pulse, start dropped during the done cycle
    op_i = 3'd0; src1 = 32'd3; src2 = 32'd4; start_i = 1'b1;
    step(1);
    dcnt = 0; bc = 0; didx = -1; res = '0;
    for (int i = 1; i <= 45; i++) begin
      if (busy_o) bc++;
      if (done_o) begin
        dcnt++;
        didx = i;
        res = Result_o;
        start_i = 1'b0;
      end
      step(1);
    end
    start_i = 1'b0;
    chk("held_start_done_count", 32'(dcnt), 32'd1);
    chk("held_start_done_cycle", 32'(didx), 32'd35);
    chk("held_start_busy", 32'(bc), 32'd35);
    chk("held_start_result", res, 32'd12);

    // Second start at cycle 10 is ignored
    start_op(3'd5, 32'd100, 32'd7);
    step(9);
    op_i = 3'd0; src1 = 32'd3; src2 = 32'd4; start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    wait_done(11, res, lat, bc);
    chk("second_start_latency", 32'(lat), 32'd35);
    chk("second_start_result", res, 32'd14);
    step(1);
    no_done("second_start_not_queued", 40);

    // start_i during the done cycle is ignored
    start_op(3'd3, 32'h8000_0000, 32'd4);
    wait_done(1, res, lat, bc);
    chk("done_cycle_latency", 32'(lat), 32'd35);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("done_cycle_start_busy", {31'd0, busy_o}, 32'd0);
    no_done("done_cycle_start_ignored", 40);
    chk("done_cycle_result", Result_o, 32'd2);

    // flush_i beats start_i in IDLE
    op_i = 3'd0; src1 = 32'd9; src2 = 32'd9; start_i = 1'b1; flush_i = 1'b1;
    step(1);
    start_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_busy", {31'd0, busy_o}, 32'd0);
    no_done("idle_flush_no_done", 40);

    // Flush at cycle 12 of a DIV
    start_op(3'd4, 32'd100, 32'd7);
    step(11);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_result_kept", Result_o, 32'd2);
    no_done("flush_no_late_done", 40);
    chk("flush_result_still", Result_o, 32'd2);
    run_op(3'd0, 32'd3, 32'd4, res, lat, bc);
    chk("post_flush_mul", res, 32'd12);
    chk("post_flush_latency", 32'(lat), 32'd35);

    // Reset at cycle 20
    start_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    step(19);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", Result_o, 32'd0);
    no_done("midrst_no_late_done", 40);
    run_op(3'd5, 32'd9, 32'd3, res, lat, bc);
    chk("post_reset_divu", res, 32'd3);
    chk("post_reset_latency", 32'(lat), 32'd35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
